handshake_fifo: RTL

Parametrised, clocked successor to the single-stage req/ack controller. It is a DEPTH-entry, WIDTH-bit elastic buffer with a req/ack handshake on both the producer side and the consumer side. The protocol is selectable between four-phase (return-to-zero) and two-phase (transition) signalling. It sits between pipeline stages in the SoC datapath and decouples producer and consumer rates while preserving order.

---
 rtl/handshake_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/handshake_fifo.sv
// handshake_fifo: DEPTH x WIDTH elastic buffer, req/ack on both sides, four-phase (PHASES=4) or two-phase (PHASES=2).
// Latency: a token captured at edge N is offered to the consumer at edge N+1 at the earliest.
// Backpressure: when full, in_ack holds its level and the producer's request stays pending until a slot frees.
//
// Ports:
//   clk, reset          single rising-edge clock, asynchronous active-high reset
//   in_req/in_data      producer request and data (data stable while request pending)
//   in_ack              registered acknowledge to producer
//   out_req/out_data    registered request and head token to consumer
//   out_ack             consumer acknowledge
//   count/full/empty    occupancy, including the token currently being offered
//
// Any PHASES value other than 4 is handled with the two-phase rules; only 2 and 4 are meaningful.
module handshake_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int PHASES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic                       out_req,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam bit FOUR = (PHASES == 4);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             pend;     // a token is being offered and awaits its acknowledge
  logic             capture;
  logic             pop;
  logic             offer;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // rp only moves on pop, so the offered token stays stable while pending
  assign out_data = mem[rp];

  // Capture uses the pre-edge count: a pop in the same cycle does not
  // make room for a new token when full.
  always_comb begin
    capture = 1'b0;
    pop     = 1'b0;
    offer   = 1'b0;
    if (FOUR) begin
      capture = in_req && !in_ack && !full;
      pop     = pend && out_ack;
      // consumer must have returned to zero before the next offer
      offer   = !pend && !empty && !out_ack;
    end else begin
      capture = (in_req != in_ack) && !full;
      pop     = pend && (out_ack == out_req);
      offer   = !pend && !empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      in_ack  <= 1'b0;
      out_req <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (capture) begin
        mem[wp] <= in_data;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end

      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (FOUR) begin
        if (capture) begin
          in_ack <= 1'b1;
        end else if (!in_req && in_ack) begin
          in_ack <= 1'b0;
        end
      end else if (capture) begin
        in_ack <= !in_ack;
      end

      // Completion clears the pending flag first; the next head is offered
      // one cycle later.
      if (pop) begin
        pend <= 1'b0;
        if (FOUR) begin
          out_req <= 1'b0;
        end
      end else if (offer) begin
        pend    <= 1'b1;
        out_req <= FOUR ? 1'b1 : !out_req;
      end
    end
  end

endmodule
